// File: rtl/accel_job_sequencer_pkg.sv
// Shared definitions for the accelerator job sequencer.
//   - Sequencer state encoding, also visible on the dbg_state port:
//     IDLE=0, START=1, WAIT_BUSY=2, WAIT_DONE=3.
//   - Default operand/result widths, shared with the accelerator datapath.
//   - Helper that decides whether the output register can take a new result.
package accel_job_sequencer_pkg;

   localparam int DEF_DW = 8;
   localparam int DEF_RW = 16;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_START     = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } seq_state_e;

   // The output slot is free when it is empty, or when the consumer takes its
   // current value in this same cycle.
   function automatic logic out_slot_free(input logic valid, input logic ready);
      return !valid || ready;
   endfunction

endpackage

// File: rtl/accel_job_sequencer_job_fifo.sv
// job_fifo: small synchronous FIFO holding operands waiting for dispatch.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   push, din     write request and data; ignored while full
//   pop           read request; ignored while empty
//   dout          head entry, visible combinationally from the storage array
//   full, empty   occupancy flags, derived from registered pointers
// DEPTH must be a power of two, >= 2. Pointers carry one extra wrap bit so
// full and empty can be told apart when the index bits match.
module job_fifo
   import accel_job_sequencer_pkg::*;
#(
   parameter int DW    = DEF_DW,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic          full,
   output logic          empty
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic          do_push, do_pop;

   always_comb begin
      full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      empty    = (wr_ptr_q == rd_ptr_q);
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      dout     = mem_q[rd_ptr_q[AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: entries are only read after being written.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/accel_job_sequencer.sv
// accel_job_sequencer: dispatcher in front of the series-evaluation accelerator.
// Operands arrive from a producer, wait in job_fifo, and are issued one at a
// time with a single-cycle start pulse. Completion is seen as acc_ready
// falling and then rising again; the result is then held for the consumer.
// A watchdog marks a hung job with a sticky timeout_err and stops dispatch.
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1; valid never waits for ready, and a valid payload stays stable
// until it is taken.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_x, in_valid, in_ready  producer side (in_ready = FIFO not full)
//   acc_ready, acc_result     accelerator idle level and result
//   acc_start, acc_x          start pulse and operand, held for the whole job
//   out_result, out_valid,
//   out_ready                 consumer side
//   busy                      sequencer active or operands pending
//   timeout_err               sticky watchdog flag, cleared only by rst
//   jobs_done                 completed jobs, wraps at 256
//   dbg_state                 current sequencer state (IDLE=0..WAIT_DONE=3)
module accel_job_sequencer
   import accel_job_sequencer_pkg::*;
#(
   parameter int DW      = DEF_DW,
   parameter int RW      = DEF_RW,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] in_x,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          acc_ready,
   output logic          acc_start,
   output logic [DW-1:0] acc_x,
   input  logic [RW-1:0] acc_result,
   output logic [RW-1:0] out_result,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          busy,
   output logic          timeout_err,
   output logic [7:0]    jobs_done,
   output logic [1:0]    dbg_state
);

   localparam int          CW        = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] WDOG_ONE  = CW'(1);
   localparam logic [CW-1:0] WDOG_LAST = CW'(TIMEOUT - 1);

   seq_state_e    state_q, state_d;
   logic [DW-1:0] acc_x_q, acc_x_d;
   logic          acc_start_q, acc_start_d;
   logic [RW-1:0] out_result_q, out_result_d;
   logic          out_valid_q, out_valid_d;
   logic          timeout_err_q, timeout_err_d;
   logic [7:0]    jobs_done_q, jobs_done_d;
   logic [CW-1:0] wdog_q, wdog_d;

   logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [DW-1:0] fifo_dout;

   assign fifo_push = in_valid && in_ready;

   job_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (in_x),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      state_d       = state_q;
      acc_x_d       = acc_x_q;
      acc_start_d   = 1'b0;
      out_result_d  = out_result_q;
      out_valid_d   = out_valid_q;
      timeout_err_d = timeout_err_q;
      jobs_done_d   = jobs_done_q;
      wdog_d        = wdog_q;
      fifo_pop      = 1'b0;

      if (out_valid_q && out_ready) out_valid_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty && acc_ready && !timeout_err_q &&
                out_slot_free(out_valid_q, out_ready)) begin
               fifo_pop    = 1'b1;
               acc_x_d     = fifo_dout;
               acc_start_d = 1'b1;
               // Cleared on the way into START and counted from START on, so
               // timeout_err rises exactly TIMEOUT cycles after the pulse.
               wdog_d      = '0;
               state_d     = ST_START;
            end
         end
         ST_START: begin
            wdog_d  = wdog_q + WDOG_ONE;
            state_d = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            wdog_d = wdog_q + WDOG_ONE;
            if (wdog_q == WDOG_LAST) begin
               timeout_err_d = 1'b1;
               state_d       = ST_IDLE;
            end else if (!acc_ready) begin
               state_d = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            wdog_d = wdog_q + WDOG_ONE;
            // A completion seen in the same cycle as the deadline still counts.
            if (acc_ready) begin
               out_result_d = acc_result;
               out_valid_d  = 1'b1;
               jobs_done_d  = jobs_done_q + 8'd1;
               state_d      = ST_IDLE;
            end else if (wdog_q == WDOG_LAST) begin
               timeout_err_d = 1'b1;
               state_d       = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         acc_x_q       <= '0;
         acc_start_q   <= 1'b0;
         out_result_q  <= '0;
         out_valid_q   <= 1'b0;
         timeout_err_q <= 1'b0;
         jobs_done_q   <= '0;
         wdog_q        <= '0;
      end else begin
         state_q       <= state_d;
         acc_x_q       <= acc_x_d;
         acc_start_q   <= acc_start_d;
         out_result_q  <= out_result_d;
         out_valid_q   <= out_valid_d;
         timeout_err_q <= timeout_err_d;
         jobs_done_q   <= jobs_done_d;
         wdog_q        <= wdog_d;
      end
   end

   assign in_ready    = !fifo_full;
   assign acc_start   = acc_start_q;
   assign acc_x       = acc_x_q;
   assign out_result  = out_result_q;
   assign out_valid   = out_valid_q;
   assign timeout_err = timeout_err_q;
   assign jobs_done   = jobs_done_q;
   assign busy        = (state_q != ST_IDLE) || !fifo_empty;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_accel_job_sequencer.sv
// Self-checking bench for accel_job_sequencer. A behavioural accelerator
// answers each start pulse with result = x*x + 11 after a programmable delay;
// the scoreboard expects results in push order.
module tb_accel_job_sequencer;

   localparam int DW = 8, RW = 16, DEPTH = 4, TIMEOUT = 255;

   // ---------------- clock / reset / DUT ----------------
   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] in_x;
   logic          in_valid, in_ready;
   logic          acc_ready, acc_start;
   logic [DW-1:0] acc_x;
   logic [RW-1:0] acc_result, out_result;
   logic          out_valid, out_ready, busy, timeout_err;
   logic [7:0]    jobs_done;
   logic [1:0]    dbg_state;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   accel_job_sequencer #(.DW(DW), .RW(RW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .in_x(in_x), .in_valid(in_valid), .in_ready(in_ready),
      .acc_ready(acc_ready), .acc_start(acc_start), .acc_x(acc_x), .acc_result(acc_result),
      .out_result(out_result), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
      .timeout_err(timeout_err), .jobs_done(jobs_done), .dbg_state(dbg_state)
   );

   // ---------------- reference model / scoreboard ----------------
   logic [RW-1:0] exp_q[$];
   int checks = 0, errors = 0;

   function automatic logic [RW-1:0] ref_result(input logic [DW-1:0] x);
      logic [RW-1:0] xx;
      xx = RW'(x);
      return xx * xx + RW'(11);
   endfunction

   // ---------------- behavioural accelerator ----------------
   int acc_drop = 2, acc_run = 10;
   bit acc_hang = 0, acc_rand = 0;
   int pulse_cnt = 0, last_start_cyc = 0, xchg_err = 0;
   int acc_phase = 0, acc_cnt = 0;
   logic [DW-1:0] cur_x;

   initial begin
      acc_ready  = 1'b1;
      acc_result = '0;
      forever begin
         @(posedge clk); #2;
         if (rst) begin
            acc_phase = 0;
            acc_ready = 1'b1;
         end else begin
            if (acc_start) pulse_cnt++;
            case (acc_phase)
               0: if (acc_start) begin
                  last_start_cyc = cyc;
                  cur_x = acc_x;
                  acc_cnt = acc_rand ? int'($urandom_range(1, 3)) : acc_drop;
                  acc_phase = 1;
               end
               1: begin
                  if (acc_x !== cur_x) xchg_err++;
                  acc_cnt--;
                  if (acc_cnt <= 0) begin
                     acc_ready = 1'b0;
                     acc_cnt = acc_rand ? int'($urandom_range(1, 8)) : acc_run;
                     acc_phase = 2;
                  end
               end
               default: begin
                  if (acc_x !== cur_x) xchg_err++;
                  if (!acc_hang) begin
                     acc_cnt--;
                     if (acc_cnt <= 0) begin
                        acc_ready = 1'b1;
                        acc_result = ref_result(cur_x);
                        acc_phase = 0;
                     end
                  end
               end
            endcase
         end
      end
   end

   // ---------------- driver tasks ----------------
   logic          pushed, took;
   logic [RW-1:0] val;

   // Called just after a falling edge: drives one cycle of producer/consumer
   // inputs, reports which transfers the next rising edge performs, and
   // returns at the following falling edge.
   task automatic step(input logic pv, input logic [DW-1:0] x, input logic rdy,
                       output logic p, output logic t, output logic [RW-1:0] v);
      in_valid  = pv;
      in_x      = x;
      out_ready = rdy;
      p = pv && in_ready;
      t = out_valid && rdy;
      v = out_result;
      if (p) exp_q.push_back(ref_result(x));
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; in_x = '0; out_ready = 1'b0;
      acc_hang = 0; acc_rand = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      checks++; if (acc_start !== 1'b0) begin errors++; $display("FAIL reset_acc_start got %0b want 0", acc_start); end
      checks++; if (acc_x !== '0) begin errors++; $display("FAIL reset_acc_x got %0h want 0", acc_x); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
      checks++; if (out_result !== '0) begin errors++; $display("FAIL reset_out_result got %0h want 0", out_result); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout got %0b want 0", timeout_err); end
      checks++; if (jobs_done !== 8'd0) begin errors++; $display("FAIL reset_jobs_done got %0d want 0", jobs_done); end
   endtask

   task automatic test_single();
      int p0, t_push;
      do_reset();
      acc_drop = 2; acc_run = 10;
      p0 = pulse_cnt; t_push = cyc;
      step(1'b1, 8'd3, 1'b0, pushed, took, val);
      for (int i = 0; i < 60 && !out_valid; i++) step(1'b0, '0, 1'b0, pushed, took, val);
      checks++; if (last_start_cyc - t_push != 2) begin errors++; $display("FAIL single_latency got %0d want 2", last_start_cyc - t_push); end
      checks++; if (pulse_cnt - p0 != 1) begin errors++; $display("FAIL single_pulses got %0d want 1", pulse_cnt - p0); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got %0b want 1", out_valid); end
      checks++; if (out_result !== 16'h0014) begin errors++; $display("FAIL single_result got %0h want 0014", out_result); end
      checks++; if (jobs_done !== 8'd1) begin errors++; $display("FAIL single_jobs_done got %0d want 1", jobs_done); end
      checks++; if (acc_x !== 8'd3) begin errors++; $display("FAIL single_acc_x got %0h want 3", acc_x); end
      step(1'b0, '0, 1'b1, pushed, took, val);
      checks++; if (!took || exp_q.size() == 0 || val !== exp_q[0]) begin errors++; $display("FAIL single_consume got took=%0b val=%0h want %0h", took, val, ref_result(8'd3)); end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_clear got %0b want 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      int got = 0;
      logic [RW-1:0] e;
      do_reset();
      acc_drop = 1; acc_run = 8;
      for (int i = 0; i < 5; i++) begin
         step(1'b1, DW'($urandom_range(0, 255)), 1'b0, pushed, took, val);
         checks++; if (!pushed) begin errors++; $display("FAIL b2b_push%0d got refused want accepted", i); end
      end
      // One operand is already with the accelerator, four are buffered.
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready got %0b want 0", in_ready); end
      for (int i = 0; i < 400 && got < 5; i++) begin
         step(1'b0, '0, 1'($urandom_range(0, 1)), pushed, took, val);
         if (took) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            got++;
            checks++; if (val !== e) begin errors++; $display("FAIL b2b_result%0d got %0h want %0h", got, val, e); end
         end
      end
      checks++; if (got != 5) begin errors++; $display("FAIL b2b_count got %0d want 5", got); end
      checks++; if (jobs_done !== 8'd5) begin errors++; $display("FAIL b2b_jobs_done got %0d want 5", jobs_done); end
      checks++; if (xchg_err != 0) begin errors++; $display("FAIL b2b_acc_x_stable got %0d changes want 0", xchg_err); end
   endtask

   task automatic test_backpressure();
      int p0, t_rel, got = 0;
      logic [RW-1:0] first, e;
      do_reset();
      acc_drop = 1; acc_run = 4;
      p0 = pulse_cnt;
      step(1'b1, DW'($urandom_range(0, 255)), 1'b0, pushed, took, val);
      step(1'b1, DW'($urandom_range(0, 255)), 1'b0, pushed, took, val);
      in_valid = 1'b0;
      for (int i = 0; i < 60 && !out_valid; i++) step(1'b0, '0, 1'b0, pushed, took, val);
      first = out_result;
      checks++; if (first !== exp_q[0]) begin errors++; $display("FAIL bp_first got %0h want %0h", first, exp_q[0]); end
      for (int i = 0; i < 30; i++) begin
         step(1'b0, '0, 1'b0, pushed, took, val);
         checks++; if (out_result !== first || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold got %0h/%0b want %0h/1", out_result, out_valid, first); end
      end
      checks++; if (pulse_cnt - p0 != 1) begin errors++; $display("FAIL bp_no_dispatch got %0d pulses want 1", pulse_cnt - p0); end
      t_rel = cyc;
      step(1'b0, '0, 1'b1, pushed, took, val);
      e = exp_q.pop_front();
      checks++; if (!took || val !== e) begin errors++; $display("FAIL bp_release got %0b/%0h want 1/%0h", took, val, e); end
      checks++; if (pulse_cnt - p0 != 2 || last_start_cyc != t_rel + 1) begin errors++; $display("FAIL bp_redispatch got pulses=%0d at +%0d want 2 at +1", pulse_cnt - p0, last_start_cyc - t_rel); end
      for (int i = 0; i < 60 && got == 0; i++) begin
         step(1'b0, '0, 1'b1, pushed, took, val);
         if (took) begin
            got++;
            e = exp_q.pop_front();
            checks++; if (val !== e) begin errors++; $display("FAIL bp_second got %0h want %0h", val, e); end
         end
      end
      checks++; if (got != 1) begin errors++; $display("FAIL bp_second_seen got %0d want 1", got); end
   endtask

   task automatic test_timeout();
      int p1;
      do_reset();
      acc_drop = 2; acc_run = 5; acc_hang = 1;
      step(1'b1, 8'h21, 1'b1, pushed, took, val);
      for (int i = 0; i < 400 && !timeout_err; i++) step(1'b0, '0, 1'b1, pushed, took, val);
      checks++; if (cyc - last_start_cyc != TIMEOUT) begin errors++; $display("FAIL to_latency got %0d want %0d", cyc - last_start_cyc, TIMEOUT); end
      checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL to_state got %0d want 0", dbg_state); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL to_out_valid got %0b want 0", out_valid); end
      acc_hang = 0;
      p1 = pulse_cnt;
      step(1'b1, 8'h42, 1'b1, pushed, took, val);
      repeat (40) step(1'b0, '0, 1'b1, pushed, took, val);
      checks++; if (pulse_cnt != p1) begin errors++; $display("FAIL to_no_dispatch got %0d pulses want 0", pulse_cnt - p1); end
      checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky got %0b want 1", timeout_err); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL to_busy got %0b want 1", busy); end
      for (int i = 0; i < 3; i++) begin
         step(1'b1, DW'(i), 1'b1, pushed, took, val);
         checks++; if (!pushed) begin errors++; $display("FAIL to_fill%0d got refused want accepted", i); end
      end
      in_valid = 1'b0;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL to_full got %0b want 0", in_ready); end
      do_reset();
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_cleared got %0b want 0", timeout_err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_reset_busy got %0b want 0", busy); end
   endtask

   task automatic test_reset_mid_job();
      int p0;
      do_reset();
      acc_drop = 1; acc_run = 20;
      step(1'b1, 8'h11, 1'b1, pushed, took, val);
      step(1'b1, 8'h22, 1'b1, pushed, took, val);
      step(1'b1, 8'h33, 1'b1, pushed, took, val);
      for (int i = 0; i < 100 && !(jobs_done == 8'd1 && dbg_state == 2'd3); i++)
         step(1'b0, '0, 1'b1, pushed, took, val);
      checks++; if (dbg_state !== 2'd3 || jobs_done !== 8'd1) begin errors++; $display("FAIL rmj_reach got state=%0d jobs=%0d want 3/1", dbg_state, jobs_done); end
      rst = 1'b1;
      step(1'b0, '0, 1'b0, pushed, took, val);
      checks++; if (acc_start !== 1'b0 || acc_x !== '0) begin errors++; $display("FAIL rmj_acc got start=%0b x=%0h want 0/0", acc_start, acc_x); end
      checks++; if (out_valid !== 1'b0 || out_result !== '0) begin errors++; $display("FAIL rmj_out got %0b/%0h want 0/0", out_valid, out_result); end
      checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rmj_fifo got busy=%0b in_ready=%0b want 0/1", busy, in_ready); end
      checks++; if (jobs_done !== 8'd0 || dbg_state !== 2'd0) begin errors++; $display("FAIL rmj_count got jobs=%0d state=%0d want 0/0", jobs_done, dbg_state); end
      rst = 1'b0;
      exp_q.delete();
      p0 = pulse_cnt;
      repeat (10) step(1'b0, '0, 1'b1, pushed, took, val);
      checks++; if (pulse_cnt != p0) begin errors++; $display("FAIL rmj_idle got %0d pulses want 0", pulse_cnt - p0); end
   endtask

   task automatic test_wrap();
      int got = 0, npush = 0;
      logic [RW-1:0] e;
      do_reset();
      acc_drop = 1; acc_run = 1;
      for (int i = 0; i < 6000 && got < 256; i++) begin
         step(npush < 256, DW'($urandom_range(0, 255)), 1'b1, pushed, took, val);
         if (pushed) npush++;
         if (took) begin
            if (got == 254) begin
               checks++; if (jobs_done !== 8'd255) begin errors++; $display("FAIL wrap_255 got %0d want 255", jobs_done); end
            end
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            got++;
            checks++; if (val !== e) begin errors++; $display("FAIL wrap_result%0d got %0h want %0h", got, val, e); end
         end
      end
      checks++; if (got != 256) begin errors++; $display("FAIL wrap_count got %0d want 256", got); end
      checks++; if (jobs_done !== 8'd0) begin errors++; $display("FAIL wrap_jobs_done got %0d want 0", jobs_done); end
   endtask

   task automatic test_random();
      int npush = 0;
      logic [RW-1:0] e;
      do_reset();
      acc_rand = 1;
      for (int i = 0; i < 600; i++) begin
         step(1'($urandom_range(0, 1)), DW'($urandom_range(0, 255)), ($urandom_range(0, 9) < 7), pushed, took, val);
         if (pushed) npush++;
         if (took) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            checks++; if (val !== e) begin errors++; $display("FAIL rand_result got %0h want %0h", val, e); end
         end
      end
      for (int i = 0; i < 2000 && (exp_q.size() != 0 || busy || out_valid); i++) begin
         step(1'b0, '0, 1'b1, pushed, took, val);
         if (took) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            checks++; if (val !== e) begin errors++; $display("FAIL rand_drain got %0h want %0h", val, e); end
         end
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_leftover got %0d want 0", exp_q.size()); end
      checks++; if (jobs_done !== 8'(npush)) begin errors++; $display("FAIL rand_jobs_done got %0d want %0d", jobs_done, 8'(npush)); end
      checks++; if (xchg_err != 0) begin errors++; $display("FAIL rand_acc_x_stable got %0d changes want 0", xchg_err); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst = 1'b1; in_valid = 1'b0; in_x = '0; out_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_timeout();
      test_reset_mid_job();
      test_wrap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL global_time_limit got expired want completion");
      $fatal(1, "simulation time limit reached");
   end

endmodule
